// File: rtl/swan128k128_kat_sequencer_if.sv
// Handshake bundle between the KAT sequencer and the SWAN-128/128 encrypt/decrypt cores.
// master: sequencer side (start/key/inp out, ready/out in); slave: core side (mirror image).
// Bit 0 of every 128-bit bus is the MSB.
interface swan128k128_kat_sequencer_if;
    logic         enc_start;
    logic [0:127] enc_key;
    logic [0:127] enc_inp;
    logic         enc_ready;
    logic [0:127] enc_out;
    logic         dec_start;
    logic [0:127] dec_key;
    logic [0:127] dec_inp;
    logic         dec_ready;
    logic [0:127] dec_out;

    modport master (
        output enc_start, enc_key, enc_inp, dec_start, dec_key, dec_inp,
        input  enc_ready, enc_out, dec_ready, dec_out
    );

    modport slave (
        input  enc_start, enc_key, enc_inp, dec_start, dec_key, dec_inp,
        output enc_ready, enc_out, dec_ready, dec_out
    );
endinterface

// File: rtl/swan128k128_kat_sequencer.sv
// Power-on known-answer-test initiator: runs 4 ROM vectors through the SWAN-128/128 enc then dec core.
// Latency: per operation START_HOLD + core latency + 1 cycles, plus 2 cycles for the whole run.
// Backpressure: each core is started only when its previous result was consumed; ready timeout = TIMEOUT cycles.
// Ports: clk/rst (async active-low), run request, cores (enc/dec start/key/inp/ready/out bundle),
//        busy, done pulse, sticky verdict pass, fail_idx, fail_dec, timeout.
module swan128k128_kat_sequencer #(
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned START_HOLD = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               run,
    swan128k128_kat_sequencer_if.master        cores,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [1:0]                         fail_idx,
    output logic                               fail_dec,
    output logic                               timeout
);
    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT);
    localparam logic [3:0] HOLD_LAST = 4'(START_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE, ENC_LOAD, ENC_WAIT, ENC_CHK, DEC_LOAD, DEC_WAIT, DEC_CHK, FINISH
    } state_t;

    function automatic logic [0:127] rom_key(input logic [1:0] i);
        case (i)
            2'd0:    rom_key = 128'h00000000000000000000000000000000;
            2'd1:    rom_key = 128'h78563412785634127856341278563412;
            2'd2:    rom_key = 128'hffeeddccbbaa00998877665544332211;
            default: rom_key = 128'hffffffffffffffffffffffffffffffff;
        endcase
    endfunction

    function automatic logic [0:127] rom_pt(input logic [1:0] i);
        case (i)
            2'd0:    rom_pt = 128'h78563412785634127856341278563412;
            2'd1:    rom_pt = 128'h11111111111111111111111111111111;
            2'd2:    rom_pt = 128'hffffffffffffffffffffffffffffffff;
            default: rom_pt = 128'hf0debc9a78563412f0debc9a78563412;
        endcase
    endfunction

    function automatic logic [0:127] rom_ct(input logic [1:0] i);
        case (i)
            2'd0:    rom_ct = 128'h7471e75b14c448bbafc68d66170d1ac9;
            2'd1:    rom_ct = 128'hfaf0220b1ac0c6ce55a98207d26e67ec;
            2'd2:    rom_ct = 128'h6f63ea4d832b7ab471080cd8fe4519bc;
            default: rom_ct = 128'h8b9d520a184f4dc8189263a70c0eebba;
        endcase
    endfunction

    state_t       state, state_nxt;
    logic [1:0]   idx, idx_nxt;
    logic [3:0]   hold_cnt, hold_nxt;
    logic [9:0]   wait_cnt, wait_nxt;
    logic [0:127] result, result_nxt;
    logic [0:127] enc_key_q, enc_key_nxt, enc_inp_q, enc_inp_nxt;
    logic [0:127] dec_key_q, dec_key_nxt, dec_inp_q, dec_inp_nxt;
    logic         pass_q, pass_nxt;
    logic [1:0]   fail_idx_q, fail_idx_nxt;
    logic         fail_dec_q, fail_dec_nxt;
    logic         timeout_q, timeout_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            hold_cnt   <= '0;
            wait_cnt   <= '0;
            result     <= '0;
            enc_key_q  <= '0;
            enc_inp_q  <= '0;
            dec_key_q  <= '0;
            dec_inp_q  <= '0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            fail_dec_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            hold_cnt   <= hold_nxt;
            wait_cnt   <= wait_nxt;
            result     <= result_nxt;
            enc_key_q  <= enc_key_nxt;
            enc_inp_q  <= enc_inp_nxt;
            dec_key_q  <= dec_key_nxt;
            dec_inp_q  <= dec_inp_nxt;
            pass_q     <= pass_nxt;
            fail_idx_q <= fail_idx_nxt;
            fail_dec_q <= fail_dec_nxt;
            timeout_q  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        hold_nxt     = hold_cnt;
        wait_nxt     = wait_cnt;
        result_nxt   = result;
        enc_key_nxt  = enc_key_q;
        enc_inp_nxt  = enc_inp_q;
        dec_key_nxt  = dec_key_q;
        dec_inp_nxt  = dec_inp_q;
        pass_nxt     = pass_q;
        fail_idx_nxt = fail_idx_q;
        fail_dec_nxt = fail_dec_q;
        timeout_nxt  = timeout_q;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt    = ENC_LOAD;
                    idx_nxt      = 2'd0;
                    hold_nxt     = '0;
                    enc_key_nxt  = rom_key(2'd0);
                    enc_inp_nxt  = rom_pt(2'd0);
                    pass_nxt     = 1'b0;
                    fail_idx_nxt = '0;
                    fail_dec_nxt = 1'b0;
                    timeout_nxt  = 1'b0;
                end
            end
            ENC_LOAD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ENC_WAIT;
                    hold_nxt  = '0;
                    wait_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            ENC_WAIT: begin
                // ready has priority over a timeout on the same cycle
                if (cores.enc_ready) begin
                    result_nxt = cores.enc_out;
                    state_nxt  = ENC_CHK;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_nxt  = 1'b1;
                    fail_idx_nxt = idx;
                    fail_dec_nxt = 1'b0;
                    state_nxt    = FINISH;
                end else begin
                    wait_nxt = wait_cnt + 10'd1;
                end
            end
            ENC_CHK: begin
                if (result == rom_ct(idx)) begin
                    state_nxt   = DEC_LOAD;
                    hold_nxt    = '0;
                    dec_key_nxt = rom_key(idx);
                    dec_inp_nxt = rom_ct(idx);
                end else begin
                    fail_idx_nxt = idx;
                    fail_dec_nxt = 1'b0;
                    state_nxt    = FINISH;
                end
            end
            DEC_LOAD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = DEC_WAIT;
                    hold_nxt  = '0;
                    wait_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            DEC_WAIT: begin
                if (cores.dec_ready) begin
                    result_nxt = cores.dec_out;
                    state_nxt  = DEC_CHK;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_nxt  = 1'b1;
                    fail_idx_nxt = idx;
                    fail_dec_nxt = 1'b1;
                    state_nxt    = FINISH;
                end else begin
                    wait_nxt = wait_cnt + 10'd1;
                end
            end
            DEC_CHK: begin
                if (result == rom_pt(idx)) begin
                    if (idx == 2'd3) begin
                        pass_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end else begin
                        idx_nxt     = idx + 2'd1;
                        hold_nxt    = '0;
                        enc_key_nxt = rom_key(idx + 2'd1);
                        enc_inp_nxt = rom_pt(idx + 2'd1);
                        state_nxt   = ENC_LOAD;
                    end
                end else begin
                    fail_idx_nxt = idx;
                    fail_dec_nxt = 1'b1;
                    state_nxt    = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cores.enc_start = (state == ENC_LOAD);
    assign cores.enc_key   = enc_key_q;
    assign cores.enc_inp   = enc_inp_q;
    assign cores.dec_start = (state == DEC_LOAD);
    assign cores.dec_key   = dec_key_q;
    assign cores.dec_inp   = dec_inp_q;

    assign busy     = (state != IDLE) && (state != FINISH);
    assign done     = (state == FINISH);
    assign pass     = pass_q;
    assign fail_idx = fail_idx_q;
    assign fail_dec = fail_dec_q;
    assign timeout  = timeout_q;
endmodule

// File: tb/tb_swan128k128_kat_sequencer.sv
// Bench for swan128k128_kat_sequencer: behavioural enc/dec cores with configurable faults,
// a run-level reference model (expected start sequence, verdict, done cycle) and one per-cycle
// compare process, plus literal expectations for latency and ROM content.
module tb_swan128k128_kat_sequencer;
    localparam int SH = 3;
    localparam int TO = 1023;

    typedef struct packed {
        logic         dec;
        logic [0:127] key;
        logic [0:127] inp;
    } op_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run = 1'b0;
    logic       busy, done, pass, fail_dec, timeout;
    logic [1:0] fail_idx;

    swan128k128_kat_sequencer_if cores();

    swan128k128_kat_sequencer #(.TIMEOUT(TO), .START_HOLD(SH)) dut (
        .clk(clk), .rst(rst), .run(run), .cores(cores),
        .busy(busy), .done(done), .pass(pass),
        .fail_idx(fail_idx), .fail_dec(fail_dec), .timeout(timeout)
    );

    always #5 clk = ~clk;

    logic [0:127] r_key [4] = '{128'h00000000000000000000000000000000,
                                128'h78563412785634127856341278563412,
                                128'hffeeddccbbaa00998877665544332211,
                                128'hffffffffffffffffffffffffffffffff};
    logic [0:127] r_pt  [4] = '{128'h78563412785634127856341278563412,
                                128'h11111111111111111111111111111111,
                                128'hffffffffffffffffffffffffffffffff,
                                128'hf0debc9a78563412f0debc9a78563412};
    logic [0:127] r_ct  [4] = '{128'h7471e75b14c448bbafc68d66170d1ac9,
                                128'hfaf0220b1ac0c6ce55a98207d26e67ec,
                                128'h6f63ea4d832b7ab471080cd8fe4519bc,
                                128'h8b9d520a184f4dc8189263a70c0eebba};

    // scenario knobs, changed only while the DUT is idle
    int lat          = 20;
    int flip_enc_v   = -1;
    int zero_dec_v   = -1;
    bit enc_never    = 1'b0;
    bit rdy_in_start = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    endtask

    task automatic chk_true(input string name, input bit cond);
        n_checks++;
        if (cond) n_pass++;
        else $display("FAIL %s: condition false at t=%0t", name, $time);
    endtask

    function automatic logic [0:127] enc_fn(input logic [0:127] k, input logic [0:127] p);
        logic [0:127] r;
        r = '1;
        for (int j = 0; j < 4; j++)
            if (k == r_key[j] && p == r_pt[j]) begin
                r = r_ct[j];
                if (j == flip_enc_v) r[127] = ~r[127];
            end
        return r;
    endfunction

    function automatic logic [0:127] dec_fn(input logic [0:127] k, input logic [0:127] c);
        logic [0:127] r;
        r = '1;
        for (int j = 0; j < 4; j++)
            if (k == r_key[j] && c == r_ct[j]) r = (j == zero_dec_v) ? '0 : r_pt[j];
        return r;
    endfunction

    // encrypt core: result valid `lat` cycles after start drops
    initial begin : enc_core
        bit           started;
        int           cnt;
        logic [0:127] k, p;
        started = 1'b0; cnt = 0; k = '0; p = '0;
        cores.enc_ready = 1'b0;
        cores.enc_out   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                started = 1'b0;
                cores.enc_ready = 1'b0;
            end else if (cores.enc_start) begin
                k = cores.enc_key; p = cores.enc_inp; started = 1'b1; cnt = 0;
                cores.enc_ready = rdy_in_start;
                cores.enc_out   = '0;
            end else if (started) begin
                cnt++;
                if (cnt == lat && !enc_never) begin
                    cores.enc_ready = 1'b1;
                    cores.enc_out   = enc_fn(k, p);
                    started = 1'b0;
                end else begin
                    cores.enc_ready = 1'b0;
                end
            end else begin
                cores.enc_ready = 1'b0;
            end
        end
    end

    initial begin : dec_core
        bit           started;
        int           cnt;
        logic [0:127] k, c;
        started = 1'b0; cnt = 0; k = '0; c = '0;
        cores.dec_ready = 1'b0;
        cores.dec_out   = '0;
        forever begin
            @(negedge clk);
            cores.dec_ready = 1'b0;
            if (!rst) begin
                started = 1'b0;
            end else if (cores.dec_start) begin
                k = cores.dec_key; c = cores.dec_inp; started = 1'b1; cnt = 0;
            end else if (started) begin
                cnt++;
                if (cnt == lat) begin
                    cores.dec_ready = 1'b1;
                    cores.dec_out   = dec_fn(k, c);
                    started = 1'b0;
                end
            end
        end
    end

    // ---------------- run-level reference model ----------------
    op_t          ops[$];
    int           exp_len;
    bit           mv_pass, mv_dec, mv_to;
    logic [1:0]   mv_idx;

    task automatic build_model();
        int total;
        ops.delete();
        total = 0;
        mv_pass = 0; mv_dec = 0; mv_to = 0; mv_idx = 2'd0;
        for (int v = 0; v < 4; v++) begin
            ops.push_back({1'b0, r_key[v], r_pt[v]});
            if (enc_never) begin
                total += SH + TO + 1; mv_to = 1; mv_idx = 2'(v); break;
            end
            total += SH + lat + 1;
            if (v == flip_enc_v) begin mv_idx = 2'(v); break; end
            ops.push_back({1'b1, r_key[v], r_ct[v]});
            total += SH + lat + 1;
            if (v == zero_dec_v) begin mv_idx = 2'(v); mv_dec = 1; break; end
            if (v == 3) mv_pass = 1;
        end
        exp_len = total;
    endtask

    int           cyc = 0;
    bit           m_active = 0;
    int           run_cyc, done_cyc;
    bit           v_pass = 0, v_dec = 0, v_to = 0;
    logic [1:0]   v_idx = 2'd0;
    op_t          cur;
    bit           cur_ok = 0;
    bit           prev_s [2] = '{1'b0, 1'b0};
    int           hold [2] = '{0, 0};
    int           enc_starts, dec_starts;
    logic [0:127] first_enc_inp, last_dec_inp;

    // single compare process
    initial begin : monitor
        logic [4:0] e_verd;
        bit         s;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("rst_status", {busy, done, pass, fail_idx, fail_dec, timeout}, '0);
                chk("rst_starts", {cores.enc_start, cores.dec_start}, '0);
                chk("rst_enc_bus", cores.enc_key | cores.enc_inp, '0);
                chk("rst_dec_bus", cores.dec_key | cores.dec_inp, '0);
                m_active = 0; ops.delete();
                v_pass = 0; v_dec = 0; v_to = 0; v_idx = 2'd0;
                prev_s[0] = 0; prev_s[1] = 0; cur_ok = 0;
            end else begin
                if (run && !m_active) begin
                    build_model();
                    m_active = 1; run_cyc = cyc; done_cyc = cyc + exp_len + 1;
                    enc_starts = 0; dec_starts = 0;
                end
                if (m_active && cyc == done_cyc) begin
                    v_pass = mv_pass; v_idx = mv_idx; v_dec = mv_dec; v_to = mv_to;
                end
                chk("busy", busy, m_active && cyc > run_cyc && cyc < done_cyc);
                chk("done", done, m_active && cyc == done_cyc);
                if (m_active && cyc > run_cyc && cyc < done_cyc) e_verd = '0;
                else e_verd = {v_pass, v_idx, v_dec, v_to};
                chk("verdict", {pass, fail_idx, fail_dec, timeout}, e_verd);
                chk("start_excl", cores.enc_start & cores.dec_start, 0);
                for (int d = 0; d < 2; d++) begin
                    s = d ? cores.dec_start : cores.enc_start;
                    if (s && !prev_s[d]) begin
                        chk_true("start_expected", ops.size() > 0);
                        cur_ok = ops.size() > 0;
                        if (cur_ok) begin
                            cur = ops.pop_front();
                            chk("op_dir", d, cur.dec);
                        end
                        if (d == 0 && enc_starts == 0) first_enc_inp = cores.enc_inp;
                        if (d == 0) enc_starts++; else dec_starts++;
                        hold[d] = 0;
                    end
                    if (s) begin
                        hold[d]++;
                        if (cur_ok) begin
                            chk("op_key", d ? cores.dec_key : cores.enc_key, cur.key);
                            chk("op_inp", d ? cores.dec_inp : cores.enc_inp, cur.inp);
                        end
                        if (d == 1) last_dec_inp = cores.dec_inp;
                    end
                    if (!s && prev_s[d]) chk("start_hold", hold[d], SH);
                    prev_s[d] = s;
                end
                if (m_active && cyc == done_cyc) begin
                    chk("ops_consumed", ops.size(), 0);
                    m_active = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_run();
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n, output bit busy1);
        bit seen;
        seen = 0; n = 0; busy1 = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (n == 1) busy1 = busy;
            if (done) seen = 1;
        end
        chk_true("done_within_budget", seen);
    endtask

    task automatic set_scn(input int l, input int fe, input int zd, input bit nv, input bit rs);
        lat = l; flip_enc_v = fe; zero_dec_v = zd; enc_never = nv; rdy_in_start = rs;
    endtask

    initial begin : main
        int n;
        bit b1;
        bit found;
        int nfall;
        bit prev;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // full passing run
        set_scn(20, -1, -1, 0, 0);
        pulse_run();
        wait_done(400, n, b1);
        chk("pass_busy_next", b1, 1);
        chk("pass_latency", n, 193);
        chk("pass_verdict", {pass, timeout}, 2'b10);
        chk("pass_starts", {8'(enc_starts), 8'(dec_starts)}, {8'd4, 8'd4});
        chk("rom_first_pt", first_enc_inp, 128'h78563412785634127856341278563412);
        chk("rom_last_ct", last_dec_inp, 128'h8b9d520a184f4dc8189263a70c0eebba);

        // encrypt result of vector 2 corrupted
        set_scn(20, 2, -1, 0, 0);
        repeat (4) @(posedge clk);
        pulse_run();
        wait_done(400, n, b1);
        chk("encflip_verdict", {pass, fail_idx, fail_dec, timeout}, 5'b0_10_0_0);
        chk("encflip_starts", {8'(enc_starts), 8'(dec_starts)}, {8'd3, 8'd2});

        // decrypt result of vector 0 zeroed
        set_scn(20, -1, 0, 0, 0);
        repeat (2) @(posedge clk);
        pulse_run();
        wait_done(400, n, b1);
        chk("deczero_latency", n, 49);
        chk("deczero_verdict", {pass, fail_idx, fail_dec, timeout}, 5'b0_00_1_0);

        // encrypt core never ready
        set_scn(20, -1, -1, 1, 0);
        repeat (3) @(posedge clk);
        pulse_run();
        wait_done(1200, n, b1);
        chk("timeout_latency", n, SH + TO + 2);
        chk("timeout_verdict", {pass, fail_idx, fail_dec, timeout}, 5'b0_00_0_1);

        // ready held during start must be ignored
        set_scn(7, -1, -1, 0, 1);
        repeat (3) @(posedge clk);
        pulse_run();
        wait_done(400, n, b1);
        chk("rdystart_latency", n, 8 * (SH + 7 + 1) + 1);
        chk("rdystart_pass", pass, 1);

        // async reset during DEC_WAIT of vector 1, then a clean rerun
        set_scn(20, -1, -1, 0, 0);
        repeat (2) @(posedge clk);
        pulse_run();
        found = 0; nfall = 0; prev = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (prev && !cores.dec_start) nfall++;
            prev = cores.dec_start;
            if (nfall == 2) found = 1;
        end
        chk_true("reach_dec_wait_v1", found);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_dec_key", cores.dec_key, '0);
        chk("arst_enc_inp", cores.enc_inp, '0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        pulse_run();
        repeat (10) @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        wait_done(400, n, b1);
        chk("rerun_latency", n, 182);
        chk("rerun_pass", pass, 1);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            int kind, v;
            kind = $urandom_range(0, 2);
            v    = $urandom_range(0, 3);
            set_scn($urandom_range(1, 30), kind == 1 ? v : -1, kind == 2 ? v : -1, 0,
                    1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 6)) @(posedge clk);
            pulse_run();
            wait_done(600, n, b1);
            chk("rand_busy_next", b1, 1);
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/swan128k128_kat_sequencer.md
Name: swan128k128_kat_sequencer

Overview:
- Synthesizable known-answer-test initiator that drives the serial SWAN-128/128 encrypt and decrypt cores through their start/ready handshake.
- Steps through an internal ROM of four vectors. Each vector is encrypted and checked, then the expected ciphertext is decrypted and checked.
- Reports a pass/fail verdict with the failing vector index and direction.
- Sits beside the cipher cores in the power-on self-test path; replaces the simulation-only stimulus.

Parameters:
- TIMEOUT, 1023, maximum cycles to wait for core ready after start deasserts; counter is 10 bits.
- START_HOLD, 1, number of cycles core start is held high while key/inp are presented (range 1-15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  one-cycle request to start a self-test; ignored while busy.
- enc_start  out  1  start to encrypt core.
- enc_key  out  [0:127]  key to encrypt core.
- enc_inp  out  [0:127]  plaintext to encrypt core.
- enc_ready  in  1  encrypt core result valid.
- enc_out  in  [0:127]  encrypt core ciphertext.
- dec_start  out  1  start to decrypt core.
- dec_key  out  [0:127]  key to decrypt core.
- dec_inp  out  [0:127]  ciphertext to decrypt core.
- dec_ready  in  1  decrypt core result valid.
- dec_out  in  [0:127]  decrypt core plaintext.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse when the verdict is final.
- pass  out  1  sticky verdict: 1 means all vectors passed.
- fail_idx  out  2  index of the failing vector.
- fail_dec  out  1  failing direction: 0 = encrypt, 1 = decrypt.
- timeout  out  1  failure caused by the ready timeout.

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0, including enc/dec_start, key and inp buses, pass, fail_idx, fail_dec and timeout.
- Vector ROM (key, plaintext, ciphertext), bit 0 = MSB:
  - 0: 0; 78563412785634127856341278563412; 7471e75b14c448bbafc68d66170d1ac9
  - 1: 78563412785634127856341278563412; 11111111111111111111111111111111; faf0220b1ac0c6ce55a98207d26e67ec
  - 2: ffeeddccbbaa00998877665544332211; ffffffffffffffffffffffffffffffff; 6f63ea4d832b7ab471080cd8fe4519bc
  - 3: ffffffffffffffffffffffffffffffff; f0debc9a78563412f0debc9a78563412; 8b9d520a184f4dc8189263a70c0eebba
- FSM states: IDLE, ENC_LOAD, ENC_WAIT, ENC_CHK, DEC_LOAD, DEC_WAIT, DEC_CHK, FINISH.
- IDLE: on run=1, go to ENC_LOAD next cycle with idx=0, busy=1, and pass/timeout/fail_idx/fail_dec cleared.
- ENC_LOAD:
  - enc_key/enc_inp = ROM[idx], enc_start=1 for exactly START_HOLD cycles.
  - Then enc_start=0 and go to ENC_WAIT.
  - Key and inp stay stable until ENC_CHK.
- ENC_WAIT:
  - The wait counter starts at 0 on the first cycle of ENC_WAIT.
  - enc_ready is ignored while enc_start=1.
  - First cycle with enc_ready=1: capture enc_out, go to ENC_CHK.
  - If the counter reaches TIMEOUT with no ready: timeout=1, fail_idx=idx, fail_dec=0, go to FINISH.
  - Ready and timeout on the same cycle: ready wins.
- ENC_CHK (1 cycle):
  - Captured value == ROM ciphertext: go to DEC_LOAD.
  - Otherwise: fail_idx=idx, fail_dec=0, go to FINISH.
- DEC_LOAD / DEC_WAIT / DEC_CHK mirror the encrypt states, with these differences:
  - dec_inp is the ROM ciphertext.
  - The result is compared against the ROM plaintext.
  - fail_dec=1 on failure.
  - On a match: if idx==3, set pass=1 and go to FINISH; else idx+1 and go to ENC_LOAD.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. Verdict outputs hold until the next accepted run.
- First mismatch or timeout aborts the run; no further vectors are executed.
- The decrypt core is never started before the same vector's encryption passes.
- Async reset mid-run aborts immediately to the reset values; the next run restarts from vector 0.
- Latency of a full passing run = sum over 8 operations of (START_HOLD + core latency + 1) + 2 cycles.

Test Plan:
- Behavioural cores that pass, fixed 20-cycle latency; pulse run -> busy rises next cycle; 8 start pulses in order enc0, dec0, …, enc3, dec3; done pulses once; pass=1, timeout=0.
- Enc core model flips bit 127 of the vector-2 output -> fail_idx=2, fail_dec=0, pass=0; dec core is never started for vector 2 and nothing is started for vector 3.
- Dec core returns 0 for vector 0 -> fail_idx=0, fail_dec=1, done after the first dec check.
- Enc core never asserts ready -> timeout=1, fail_idx=0, fail_dec=0; done exactly TIMEOUT cycles after enc_start falls (+1).
- Hold enc_ready high during enc_start with START_HOLD=3 -> not accepted; the result is taken only after start drops.
- Assert rst low during DEC_WAIT of vector 1, release, pulse run -> all outputs 0 after reset; the second run is a full pass starting at vector 0. A run pulse while busy has no effect.
